// File: rtl/mem_dma_copy.sv
// Byte-serial memory-to-memory copy engine with read/write strobes.
// Optional constant-fill mode is enabled by defining DMA_FILL_EN.
module mem_dma_copy #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W-1:0] len,
`ifdef DMA_FILL_EN
   input  logic              fill,
   input  logic [7:0]        fill_val,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              mem_rd,
   output logic              mem_wr
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      FIN
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [ADDR_W-1:0] count;
   logic [7:0]        data_buf;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q;
   logic              start_fill;
   logic              fill_mode;
   logic [7:0]        fill_byte;
   logic [7:0]        wr_byte;
   logic              accept;

`ifdef DMA_FILL_EN
   logic       fill_q;
   logic [7:0] fill_val_q;

   // Latch fill mode and fill byte together with the transfer parameters
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q     <= 1'b0;
         fill_val_q <= 8'h00;
      end else if (accept) begin
         fill_q     <= fill;
         fill_val_q <= fill_val;
      end
   end

   assign start_fill = fill;
   assign fill_mode  = fill_q;
   assign fill_byte  = fill_val_q;
`else
   assign start_fill = 1'b0;
   assign fill_mode  = 1'b0;
   assign fill_byte  = 8'h00;
`endif

   assign accept  = (state == IDLE) && start;
   assign wr_byte = fill_mode ? fill_byte : data_buf;

   // Next state and bus outputs; address/data hold last value when idle
   always_comb begin
      state_n   = state;
      busy      = 1'b0;
      done      = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (len == '0)
                  state_n = FIN;
               else if (start_fill)
                  state_n = WRITE;
               else
                  state_n = READ;
            end
         end
         READ: begin
            busy     = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = src_ptr;
            state_n  = WRITE;
         end
         WRITE: begin
            busy      = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = dst_ptr;
            mem_wdata = wr_byte;
            if (count == ADDR_W'(1))
               state_n = FIN;
            else if (fill_mode)
               state_n = WRITE;
            else
               state_n = READ;
         end
         FIN: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State, pointers, count, read buffer and held bus values
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         src_ptr  <= '0;
         dst_ptr  <= '0;
         count    <= '0;
         data_buf <= 8'h00;
         addr_q   <= '0;
         wdata_q  <= 8'h00;
      end else begin
         state   <= state_n;
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
         if (accept) begin
            src_ptr <= src;
            dst_ptr <= dst;
            count   <= len;
         end
         if (state == READ)
            data_buf <= mem_rdata;
         if (state == WRITE) begin
            src_ptr <= src_ptr + ADDR_W'(1);
            dst_ptr <= dst_ptr + ADDR_W'(1);
            count   <= count - ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_dma_copy.sv
// Directed self-checking bench for mem_dma_copy with a 64 KiB byte memory.
// Fill-mode vectors are included when DMA_FILL_EN is defined.
module tb_mem_dma_copy;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] src;
   logic [15:0] dst;
   logic [15:0] len;
`ifdef DMA_FILL_EN
   logic        fill;
   logic [7:0]  fill_val;
`endif
   logic        busy;
   logic        done;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_rd;
   logic        mem_wr;

   logic [7:0]  mem [0:65535];

   int n_cmp = 0;
   int n_bad = 0;

   int rd_n = 0;
   int wr_n = 0;
   int done_n = 0;
   int busy_n = 0;
   int both_n = 0;
   int stray_n = 0;
   logic [15:0] rd_a[$];
   logic [15:0] wr_a[$];

   int b_rd;
   int b_wr;
   int b_done;
   int b_busy;
   int b_ra;
   int b_wa;

   mem_dma_copy #(.ADDR_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src       (src),
      .dst       (dst),
      .len       (len),
`ifdef DMA_FILL_EN
      .fill      (fill),
      .fill_val  (fill_val),
`endif
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_wr)
         mem[mem_addr] <= mem_wdata;
   end

   always @(negedge clk) begin
      if (mem_rd) begin
         rd_n = rd_n + 1;
         rd_a.push_back(mem_addr);
      end
      if (mem_wr) begin
         wr_n = wr_n + 1;
         wr_a.push_back(mem_addr);
      end
      if (done)
         done_n = done_n + 1;
      if (busy)
         busy_n = busy_n + 1;
      if (mem_rd && mem_wr)
         both_n = both_n + 1;
      if ((mem_rd || mem_wr) && !busy)
         stray_n = stray_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      b_rd   = rd_n;
      b_wr   = wr_n;
      b_done = done_n;
      b_busy = busy_n;
      b_ra   = rd_a.size();
      b_wa   = wr_a.size();
   endtask

   task automatic kick(input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l);
      snap();
      start = 1'b1;
      src   = s;
      dst   = d;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (done_n != b_done)
            break;
         tick();
      end
      chk(tag, 32'(done_n != b_done), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++)
         mem[i] = 8'h00;
      rst   = 1'b1;
      start = 1'b0;
      src   = '0;
      dst   = '0;
      len   = '0;
`ifdef DMA_FILL_EN
      fill     = 1'b0;
      fill_val = 8'h00;
`endif
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd", 32'(mem_rd), 32'd0);
      chk("rst_wr", 32'(mem_wr), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_wdata", 32'(mem_wdata), 32'h0);
      rst = 1'b0;
      tick();

      mem[16'h0100] = 8'h11;
      mem[16'h0101] = 8'h22;
      mem[16'h0102] = 8'h33;
      mem[16'h0103] = 8'h44;
      mem[16'h0104] = 8'h55;
      kick(16'h0100, 16'h0200, 16'd4);
      chk("cp_busy_rise", 32'(busy), 32'd1);
      wait_done("cp_done_seen");
      tick();
      chk("cp_b0", 32'(mem[16'h0200]), 32'h11);
      chk("cp_b1", 32'(mem[16'h0201]), 32'h22);
      chk("cp_b2", 32'(mem[16'h0202]), 32'h33);
      chk("cp_b3", 32'(mem[16'h0203]), 32'h44);
      chk("cp_busy_cyc", 32'(busy_n - b_busy), 32'd8);
      chk("cp_done_cnt", 32'(done_n - b_done), 32'd1);
      chk("cp_rd_cnt", 32'(rd_n - b_rd), 32'd4);
      chk("cp_wr_cnt", 32'(wr_n - b_wr), 32'd4);
      chk("cp_hold_addr", 32'(mem_addr), 32'h0203);
      chk("cp_hold_wdata", 32'(mem_wdata), 32'h44);

      kick(16'h0100, 16'h0900, 16'd0);
      chk("z_done", 32'(done), 32'd1);
      chk("z_busy", 32'(busy), 32'd0);
      tick();
      chk("z_done_off", 32'(done), 32'd0);
      tick();
      chk("z_rd", 32'(rd_n - b_rd), 32'd0);
      chk("z_wr", 32'(wr_n - b_wr), 32'd0);
      chk("z_dst", 32'(mem[16'h0900]), 32'h00);

      mem[16'hFFFE] = 8'h5A;
      mem[16'hFFFF] = 8'h6B;
      mem[16'h0000] = 8'h7C;
      kick(16'hFFFE, 16'h0010, 16'd3);
      wait_done("wr_done_seen");
      tick();
      chk("wr_ra0", 32'(rd_a[b_ra]), 32'hFFFE);
      chk("wr_ra1", 32'(rd_a[b_ra+1]), 32'hFFFF);
      chk("wr_ra2", 32'(rd_a[b_ra+2]), 32'h0000);
      chk("wr_wa0", 32'(wr_a[b_wa]), 32'h0010);
      chk("wr_wa2", 32'(wr_a[b_wa+2]), 32'h0012);
      chk("wr_d0", 32'(mem[16'h0010]), 32'h5A);
      chk("wr_d1", 32'(mem[16'h0011]), 32'h6B);
      chk("wr_d2", 32'(mem[16'h0012]), 32'h7C);

      kick(16'h0100, 16'h0400, 16'd5);
      for (int i = 0; i < 50; i++) begin
         if (wr_n - b_wr >= 2)
            break;
         tick();
      end
      chk("ab_two_writes", 32'(wr_n - b_wr), 32'd2);
      rst   = 1'b1;
      start = 1'b1;
      src   = 16'h0100;
      dst   = 16'h0A00;
      len   = 16'd3;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      tick();
      tick();
      chk("ab_idle", 32'(busy), 32'd0);
      chk("ab_wr_cnt", 32'(wr_n - b_wr), 32'd2);
      chk("ab_no_done", 32'(done_n - b_done), 32'd0);
      chk("ab_m0", 32'(mem[16'h0400]), 32'h11);
      chk("ab_m1", 32'(mem[16'h0401]), 32'h22);
      chk("ab_m2", 32'(mem[16'h0402]), 32'h00);
      chk("ab_prio", 32'(mem[16'h0A00]), 32'h00);

      kick(16'h0102, 16'h0500, 16'd2);
      wait_done("re_done_seen");
      tick();
      chk("re_m0", 32'(mem[16'h0500]), 32'h33);
      chk("re_m1", 32'(mem[16'h0501]), 32'h44);

      kick(16'h0100, 16'h0600, 16'd4);
      tick();
      tick();
      start = 1'b1;
      src   = 16'h0000;
      dst   = 16'h0700;
      len   = 16'd2;
      tick();
      start = 1'b0;
      wait_done("ig_done_seen");
      tick();
      tick();
      chk("ig_done_cnt", 32'(done_n - b_done), 32'd1);
      chk("ig_busy_cyc", 32'(busy_n - b_busy), 32'd8);
      chk("ig_wr_cnt", 32'(wr_n - b_wr), 32'd4);
      chk("ig_m0", 32'(mem[16'h0600]), 32'h11);
      chk("ig_m3", 32'(mem[16'h0603]), 32'h44);
      chk("ig_other", 32'(mem[16'h0700]), 32'h00);

      mem[16'h0800] = 8'hAB;
      kick(16'h0800, 16'h0801, 16'd3);
      wait_done("ov_done_seen");
      tick();
      chk("ov_m1", 32'(mem[16'h0801]), 32'hAB);
      chk("ov_m2", 32'(mem[16'h0802]), 32'hAB);
      chk("ov_m3", 32'(mem[16'h0803]), 32'hAB);

`ifdef DMA_FILL_EN
      fill     = 1'b1;
      fill_val = 8'hA5;
      kick(16'h0100, 16'h0300, 16'd4);
      fill     = 1'b0;
      fill_val = 8'h00;
      wait_done("fl_done_seen");
      tick();
      chk("fl_m0", 32'(mem[16'h0300]), 32'hA5);
      chk("fl_m1", 32'(mem[16'h0301]), 32'hA5);
      chk("fl_m2", 32'(mem[16'h0302]), 32'hA5);
      chk("fl_m3", 32'(mem[16'h0303]), 32'hA5);
      chk("fl_busy_cyc", 32'(busy_n - b_busy), 32'd4);
      chk("fl_rd", 32'(rd_n - b_rd), 32'd0);
      chk("fl_done_cnt", 32'(done_n - b_done), 32'd1);
`endif

      chk("rd_wr_overlap", 32'(both_n), 32'd0);
      chk("strobe_idle", 32'(stray_n), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_dma_copy.md
MEM_DMA_COPY -- requirements
Module: mem_dma_copy

Interface
- REQ-001: Parameter ADDR_W, default 16, SHALL set the memory address width and the width of the src, dst, len and mem_addr ports.
- REQ-002: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
- REQ-003: rst  input  1  SHALL be the synchronous, active-high reset.
- REQ-004: start  input  1  SHALL request a transfer; sampled only in IDLE.
- REQ-005: src  input  ADDR_W  SHALL be the first source byte address, latched on accepted start.
- REQ-006: dst  input  ADDR_W  SHALL be the first destination byte address, latched on accepted start.
- REQ-007: len  input  ADDR_W  SHALL be the byte count, latched on accepted start.
- REQ-008: busy  output  1  SHALL be high while a transfer is in progress.
- REQ-009: done  output  1  SHALL be a one-cycle completion pulse.
- REQ-010: mem_addr  output  ADDR_W  SHALL be the byte address to the memory responder.
- REQ-011: mem_wdata  output  8  SHALL be the write data to the memory responder.
- REQ-012: mem_rdata  input  8  SHALL be the read data from the memory responder, valid in the same cycle as mem_addr (combinational read).
- REQ-013: mem_rd  output  1  SHALL be the read strobe.
- REQ-014: mem_wr  output  1  SHALL be the write strobe; the responder commits on the next rising edge.

Function
- REQ-015: The state machine SHALL have the states IDLE, READ, WRITE and FIN.
- REQ-016: IDLE with start=1 and len!=0 SHALL latch src, dst and len, then go to READ; busy SHALL rise in the next cycle.
- REQ-017: IDLE with start=1 and len=0 SHALL go to FIN with no mem_rd or mem_wr asserted.
- REQ-018: READ SHALL drive mem_addr=src_ptr and mem_rd=1, capture mem_rdata into an 8-bit buffer at the clock edge, then go to WRITE.
- REQ-019: WRITE SHALL drive mem_addr=dst_ptr, mem_wdata=buffer and mem_wr=1; at the edge it SHALL increment both pointers and decrement the count.
- REQ-020: WRITE SHALL go to FIN if the count was 1, otherwise back to READ.
- REQ-021: A copy of N bytes SHALL take exactly 2N cycles in READ/WRITE.
- REQ-022: FIN SHALL assert done=1 and busy=0 for one cycle, then go to IDLE.
- REQ-023: Pointers SHALL wrap modulo 2^ADDR_W (0xFFFF+1 -> 0x0000 at the default width).
- REQ-024: The copy SHALL be forward and byte-serial; overlapping regions with dst>src SHALL replicate the source pattern and SHALL NOT be treated as an error.
- REQ-025: start outside IDLE SHALL be ignored, with no effect on the transfer in progress.
- REQ-026: mem_rd and mem_wr SHALL never be high together; both SHALL be 0 in IDLE and FIN.
- REQ-027: mem_addr and mem_wdata SHALL hold their last values when no strobe is active.

Reset
- REQ-028: rst=1 SHALL force IDLE, busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0 and clear the pointers, count and buffer at the next edge.
- REQ-029: rst asserted mid-transfer SHALL abort it with no done pulse; bytes already written SHALL remain in memory.
- REQ-030: rst SHALL have priority over start in the same cycle.

Configuration
- REQ-031: With DMA_FILL_EN defined, the module SHALL have the ports fill (input, 1) and fill_val (input, 8), both latched on accepted start.
- REQ-032: With DMA_FILL_EN defined and fill=1, the engine SHALL skip READ and stay in WRITE, writing fill_val to consecutive dst addresses, one byte per cycle, taking N cycles for N bytes; src SHALL be ignored and mem_rd SHALL stay 0.
- REQ-033: Without DMA_FILL_EN, the fill and fill_val ports SHALL be absent and behaviour SHALL be copy-only as specified above.

Verification
- REQ-034: Memory 0x0100..0x0103 = 11 22 33 44; start with src=0x0100, dst=0x0200, len=4 -> 0x0200..0x0203 = 11 22 33 44; busy high for 8 cycles; done pulses once.
- REQ-035: len=0 -> done pulses 1 cycle after start; no mem_rd or mem_wr observed.
- REQ-036: src=0xFFFE, dst=0x0010, len=3 -> reads 0xFFFE, 0xFFFF, 0x0000; writes 0x0010..0x0012.
- REQ-037: Reset asserted after the 2nd write of a len=5 copy -> 2 bytes written, busy=0 next cycle, no done pulse; a new start is then accepted normally.
- REQ-038: start pulsed mid-transfer with different src/dst/len -> no effect on the transfer, exactly one done pulse.
- REQ-039: DMA_FILL_EN defined, fill=1, fill_val=0xA5, dst=0x0300, len=4 -> 0x0300..0x0303 = A5; done after 4 write cycles; mem_rd never asserted.
